// File: rtl/alu_sequencer.sv
// Single-issue sequencer for the 8-bit ALU result mux: accepts one instruction,
// holds the mux select for HOLD_CYCLES, captures the result into acc/breg.
module alu_sequencer #(
    parameter int HOLD_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [3:0] instr_op,
    input  logic       instr_load,
    input  logic [7:0] instr_imm,
    output logic [3:0] alu_sel,
    output logic       alu_en,
    output logic [7:0] load_val,
    input  logic [7:0] alu_data,
    output logic [7:0] acc,
    output logic [7:0] breg,
    output logic       flag_zero,
    output logic       done,
    output logic       busy,
    output logic [7:0] retired
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [3:0] HOLD_INIT = 4'(HOLD_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] sel_q, sel_d;
    logic       en_q, en_d;
    logic [7:0] lv_q, lv_d;
    logic [7:0] acc_q, acc_d;
    logic [7:0] breg_q, breg_d;
    logic       zero_q, zero_d;
    logic       done_q, done_d;
    logic       busy_q, busy_d;
    logic       ready_q, ready_d;
    logic [7:0] ret_q, ret_d;

    // Next-state and next-output computation for the issue/capture sequence.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        en_d    = en_q;
        lv_d    = lv_q;
        acc_d   = acc_q;
        breg_d  = breg_q;
        zero_d  = zero_q;
        done_d  = 1'b0;
        ret_d   = ret_q;
        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    sel_d   = instr_op;
                    en_d    = ~instr_load;
                    lv_d    = instr_imm;
                    cnt_d   = HOLD_INIT;
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_CAPTURE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_CAPTURE: begin
                acc_d = alu_data;
                // en_q still reflects ~load here; STO (1110) and SWP (1111) move acc into breg.
                if (en_q && (sel_q[3:1] == 3'b111)) begin
                    breg_d = acc_q;
                end else begin
                    breg_d = breg_q;
                end
                zero_d  = (alu_data == 8'h00);
                done_d  = 1'b1;
                ret_d   = ret_q + 8'd1;
                en_d    = 1'b0;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d  = (state_d != S_IDLE);
        ready_d = (state_d == S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            sel_q   <= 4'd0;
            en_q    <= 1'b0;
            lv_q    <= 8'h00;
            acc_q   <= 8'h00;
            breg_q  <= 8'h00;
            zero_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            ret_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            en_q    <= en_d;
            lv_q    <= lv_d;
            acc_q   <= acc_d;
            breg_q  <= breg_d;
            zero_q  <= zero_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            ret_q   <= ret_d;
        end
    end

    assign instr_ready = ready_q;
    assign alu_sel     = sel_q;
    assign alu_en      = en_q;
    assign load_val    = lv_q;
    assign acc         = acc_q;
    assign breg        = breg_q;
    assign flag_zero   = zero_q;
    assign done        = done_q;
    assign busy        = busy_q;
    assign retired     = ret_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: two instances (HOLD_CYCLES 1 and 4) share stimulus and are
// checked every cycle against a transaction-timed reference model plus directed literals.
module tb_alu_sequencer;

    localparam int H0 = 1;
    localparam int H1 = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       instr_valid = 1'b0;
    logic [3:0] instr_op = 4'd0;
    logic       instr_load = 1'b0;
    logic [7:0] instr_imm = 8'h00;
    logic       force_en = 1'b0;
    logic [7:0] force_val = 8'h00;

    logic       ready_o[2], en_o[2], zero_o[2], done_o[2], busy_o[2];
    logic [3:0] sel_o[2];
    logic [7:0] lv_o[2], acc_o[2], breg_o[2], ret_o[2], data_i[2];

    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    // Environment ALU result mux; SWP returns B so the sequencer performs a true swap.
    function automatic logic [7:0] alu_fn(input logic en, input logic [3:0] sel,
                                          input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] lv);
        if (!en) return lv;
        case (sel)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return ~a;
            4'd6:    return a << 1;
            4'd7:    return a >> 1;
            4'd8:    return a + 8'd1;
            4'd9:    return a - 8'd1;
            4'd10:   return b;
            4'd11:   return a;
            4'd12:   return {a[3:0], a[7:4]};
            4'd13:   return ~(a & b);
            4'd14:   return a;
            default: return b;
        endcase
    endfunction

    assign data_i[0] = force_en ? force_val : alu_fn(en_o[0], sel_o[0], acc_o[0], breg_o[0], lv_o[0]);
    assign data_i[1] = force_en ? force_val : alu_fn(en_o[1], sel_o[1], acc_o[1], breg_o[1], lv_o[1]);

    alu_sequencer #(.HOLD_CYCLES(H0)) dut0 (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(ready_o[0]),
        .instr_op(instr_op), .instr_load(instr_load), .instr_imm(instr_imm),
        .alu_sel(sel_o[0]), .alu_en(en_o[0]), .load_val(lv_o[0]), .alu_data(data_i[0]),
        .acc(acc_o[0]), .breg(breg_o[0]), .flag_zero(zero_o[0]), .done(done_o[0]),
        .busy(busy_o[0]), .retired(ret_o[0])
    );

    alu_sequencer #(.HOLD_CYCLES(H1)) dut1 (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(ready_o[1]),
        .instr_op(instr_op), .instr_load(instr_load), .instr_imm(instr_imm),
        .alu_sel(sel_o[1]), .alu_en(en_o[1]), .load_val(lv_o[1]), .alu_data(data_i[1]),
        .acc(acc_o[1]), .breg(breg_o[1]), .flag_zero(zero_o[1]), .done(done_o[1]),
        .busy(busy_o[1]), .retired(ret_o[1])
    );

    // Reference model: m_c counts cycles since the accepting edge (0 = idle).
    int         m_c[2];
    logic [3:0] m_sel[2];
    logic       m_en[2], m_ld[2], m_flag[2];
    logic [7:0] m_lv[2], m_acc[2], m_breg[2], m_ret[2];

    function automatic int hold_of(input int i);
        return (i == 0) ? H0 : H1;
    endfunction

    function automatic logic [7:0] cap_val(input int i);
        if (force_en) return force_val;
        if (m_ld[i]) return m_lv[i];
        return alu_fn(1'b1, m_sel[i], m_acc[i], m_breg[i], 8'h00);
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_c[i] <= 0; m_sel[i] <= 4'd0; m_en[i] <= 1'b0; m_ld[i] <= 1'b0;
                m_lv[i] <= 8'h00; m_acc[i] <= 8'h00; m_breg[i] <= 8'h00;
                m_flag[i] <= 1'b0; m_ret[i] <= 8'h00;
            end else if (m_c[i] == 0) begin
                if (instr_valid) begin
                    m_c[i] <= 1; m_sel[i] <= instr_op; m_en[i] <= ~instr_load;
                    m_ld[i] <= instr_load; m_lv[i] <= instr_imm;
                end
            end else if (m_c[i] <= hold_of(i)) begin
                m_c[i] <= m_c[i] + 1;
            end else if (m_c[i] == hold_of(i) + 1) begin
                m_acc[i]  <= cap_val(i);
                m_flag[i] <= (cap_val(i) == 8'h00);
                if (!m_ld[i] && m_sel[i] >= 4'd14) m_breg[i] <= m_acc[i];
                m_ret[i]  <= m_ret[i] + 8'd1;
                m_en[i]   <= 1'b0;
                m_c[i]    <= m_c[i] + 1;
            end else begin
                m_c[i] <= 0;
            end
        end
    end

    task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] @%0t: got %0h expected %0h", nm, inst, $time, act, exp);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < 2; i++) begin
                chk("ready", i, {31'd0, ready_o[i]}, {31'd0, m_c[i] == 0});
                chk("busy",  i, {31'd0, busy_o[i]},  {31'd0, m_c[i] != 0});
                chk("done",  i, {31'd0, done_o[i]},  {31'd0, m_c[i] == hold_of(i) + 2});
                chk("alu_en",   i, {31'd0, en_o[i]}, {31'd0, m_en[i]});
                chk("alu_sel",  i, {28'd0, sel_o[i]}, {28'd0, m_sel[i]});
                chk("load_val", i, {24'd0, lv_o[i]},  {24'd0, m_lv[i]});
                chk("acc",      i, {24'd0, acc_o[i]}, {24'd0, m_acc[i]});
                chk("breg",     i, {24'd0, breg_o[i]}, {24'd0, m_breg[i]});
                chk("zero",     i, {31'd0, zero_o[i]}, {31'd0, m_flag[i]});
                chk("retired",  i, {24'd0, ret_o[i]}, {24'd0, m_ret[i]});
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Issue one instruction from an idle negedge; valid stays high for hold_valid cycles.
    task automatic run_instr(input logic ld, input logic [3:0] op, input logic [7:0] imm,
                             input int hold_valid, output int lat0, output int lat1,
                             output int en_cyc1, output logic [3:0] sel_i,
                             output logic en_i, output logic [7:0] lv_i);
        instr_valid = 1'b1; instr_load = ld; instr_op = op; instr_imm = imm;
        lat0 = -1; lat1 = -1; en_cyc1 = 0; sel_i = 4'hx; en_i = 1'bx; lv_i = 8'hxx;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) begin sel_i = sel_o[0]; en_i = en_o[0]; lv_i = lv_o[0]; end
            if (k >= hold_valid) begin
                instr_valid = 1'b0;
                instr_op = 4'($urandom);
                instr_imm = 8'($urandom);
                instr_load = 1'($urandom);
            end
            if (done_o[0] && lat0 < 0) lat0 = k;
            if (done_o[1] && lat1 < 0) lat1 = k;
            if (en_o[1]) en_cyc1++;
            if (k >= hold_valid && lat0 >= 0 && lat1 >= 0 && !busy_o[0] && !busy_o[1]) break;
        end
    endtask

    int         l0, l1, ec, dcnt;
    logic [3:0] s_i;
    logic       e_i;
    logic [7:0] v_i;

    initial begin
        @(negedge clk);
        do_reset();
        chk_on = 1'b1;
        chk("rst_ready", 0, {31'd0, ready_o[0]}, 32'd1);
        chk("rst_acc",   0, {24'd0, acc_o[0]}, 32'd0);
        chk("rst_busy",  0, {31'd0, busy_o[0]}, 32'd0);
        chk("rst_ret",   1, {24'd0, ret_o[1]}, 32'd0);

        run_instr(1'b1, 4'd7, 8'h05, 1, l0, l1, ec, s_i, e_i, v_i);
        chk("ld5_en_issue", 0, {31'd0, e_i}, 32'd0);
        chk("ld5_lv_issue", 0, {24'd0, v_i}, 32'h05);
        chk("ld5_lat0", 0, l0, 32'd3);
        chk("ld5_lat1", 1, l1, 32'd6);
        chk("ld5_acc",  0, {24'd0, acc_o[0]}, 32'h05);
        chk("ld5_ret",  0, {24'd0, ret_o[0]}, 32'd1);
        chk("ld5_zero", 0, {31'd0, zero_o[0]}, 32'd0);

        run_instr(1'b1, 4'd3, 8'h00, 1, l0, l1, ec, s_i, e_i, v_i);
        chk("ld0_acc",  0, {24'd0, acc_o[0]}, 32'h00);
        chk("ld0_zero", 0, {31'd0, zero_o[0]}, 32'd1);

        force_en = 1'b1; force_val = 8'h03;
        run_instr(1'b0, 4'd0, 8'hAA, 1, l0, l1, ec, s_i, e_i, v_i);
        force_en = 1'b0;
        chk("add_sel",  0, {28'd0, s_i}, 32'd0);
        chk("add_en",   0, {31'd0, e_i}, 32'd1);
        chk("add_acc",  0, {24'd0, acc_o[0]}, 32'h03);
        chk("add_zero", 0, {31'd0, zero_o[0]}, 32'd0);

        do_reset();
        run_instr(1'b1, 4'd0, 8'h3C, 1, l0, l1, ec, s_i, e_i, v_i);
        run_instr(1'b0, 4'd15, 8'h00, 1, l0, l1, ec, s_i, e_i, v_i);
        chk("swp_acc",  0, {24'd0, acc_o[0]}, 32'h00);
        chk("swp_breg", 0, {24'd0, breg_o[0]}, 32'h3C);
        chk("swp_breg", 1, {24'd0, breg_o[1]}, 32'h3C);

        do_reset();
        run_instr(1'b0, 4'd2, 8'h00, 7, l0, l1, ec, s_i, e_i, v_i);
        chk("hold4_lat",   1, l1, 32'd6);
        chk("hold4_en",    1, ec, 32'd5);
        chk("hold4_ret",   1, {24'd0, ret_o[1]}, 32'd1);
        chk("hold1_reacc", 0, {24'd0, ret_o[0]}, 32'd2);

        do_reset();
        run_instr(1'b1, 4'd0, 8'h3C, 1, l0, l1, ec, s_i, e_i, v_i);
        instr_valid = 1'b1; instr_load = 1'b0; instr_op = 4'd0;
        @(negedge clk);
        instr_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_acc",   0, {24'd0, acc_o[0]}, 32'd0);
        chk("midrst_done",  0, {31'd0, done_o[0]}, 32'd0);
        chk("midrst_ret",   0, {24'd0, ret_o[0]}, 32'd0);
        chk("midrst_ready", 0, {31'd0, ready_o[0]}, 32'd1);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        chk("midrst_nodone", 1, {24'd0, ret_o[1]}, 32'd0);

        do_reset();
        dcnt = 0;
        instr_valid = 1'b1; instr_load = 1'b1;
        for (int k = 0; k < 2000; k++) begin
            instr_imm = 8'($urandom);
            instr_op = 4'($urandom);
            @(negedge clk);
            if (done_o[0]) dcnt++;
            if (dcnt == 256) break;
        end
        instr_valid = 1'b0;
        chk("wrap_done_cnt", 0, dcnt, 32'd256);
        chk("wrap_ret",      0, {24'd0, ret_o[0]}, 32'd0);
        repeat (8) @(negedge clk);

        for (int k = 0; k < 3000; k++) begin
            reset       = ($urandom_range(0, 299) == 0);
            instr_valid = ($urandom_range(0, 9) < 6);
            instr_load  = ($urandom_range(0, 3) == 0);
            instr_op    = 4'($urandom);
            instr_imm   = 8'($urandom);
            @(negedge clk);
        end
        reset = 1'b0;
        instr_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
